// File: rtl/axi_rd_arbiter.sv
// Two-channel round-robin arbiter sharing one AXI read port.
// One burst in flight at a time: a request is latched, issued on AR and its R beats are steered back to the owner.
module axi_rd_arbiter #(
    parameter logic [3:0] AXI_ID    = 4'd0,
    parameter logic [2:0] AXI_SIZE  = 3'b011,
    parameter logic [1:0] AXI_BURST = 2'b01
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        ch0_rd_req,
    input  logic [29:0] ch0_rd_addr,
    input  logic [7:0]  ch0_rd_len,
    output logic        ch0_rd_grant,
    output logic [63:0] ch0_rd_data,
    output logic        ch0_rd_valid,
    output logic        ch0_rd_done,

    input  logic        ch1_rd_req,
    input  logic [29:0] ch1_rd_addr,
    input  logic [7:0]  ch1_rd_len,
    output logic        ch1_rd_grant,
    output logic [63:0] ch1_rd_data,
    output logic        ch1_rd_valid,
    output logic        ch1_rd_done,

    output logic [3:0]  m_axi_arid,
    output logic [29:0] m_axi_araddr,
    output logic [7:0]  m_axi_arlen,
    output logic [2:0]  m_axi_arsize,
    output logic [1:0]  m_axi_arburst,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,

    input  logic [63:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rlast,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,

    output logic        rd_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        owner;
    logic        last_served;
    logic        winner;
    logic        any_req;
    logic        beat;
    logic        beat_err;
    logic [7:0]  beat_cnt;
    logic        grant0;
    logic        grant1;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        state_next = state;
        any_req    = ch0_rd_req | ch1_rd_req;
        // Contention goes to the channel not served last; a lone requester wins outright.
        winner     = (ch0_rd_req & ch1_rd_req) ? ~last_served : ch1_rd_req;
        beat       = m_axi_rvalid & m_axi_rready;
        beat_err   = beat & ((m_axi_rresp != 2'b00) |
                             ( m_axi_rlast & (beat_cnt != m_axi_arlen)) |
                             (~m_axi_rlast & (beat_cnt == m_axi_arlen)));
        case (state)
            IDLE:    if (any_req) state_next = AR;
            AR:      if (m_axi_arvalid & m_axi_arready) state_next = R;
            R:       if (beat & m_axi_rlast) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner         <= 1'b0;
            last_served   <= 1'b1;
            m_axi_araddr  <= 30'd0;
            m_axi_arlen   <= 8'd0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            beat_cnt      <= 8'd0;
            grant0        <= 1'b0;
            grant1        <= 1'b0;
            rd_err        <= 1'b0;
        end else begin
            grant0 <= 1'b0;
            grant1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner         <= winner;
                        m_axi_araddr  <= winner ? ch1_rd_addr : ch0_rd_addr;
                        m_axi_arlen   <= winner ? ch1_rd_len : ch0_rd_len;
                        m_axi_arvalid <= 1'b1;
                        grant0        <= ~winner;
                        grant1        <= winner;
                    end
                end
                AR: begin
                    if (m_axi_arvalid & m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        beat_cnt      <= 8'd0;
                    end
                end
                R: begin
                    // rlast alone ends the burst, even when the beat count disagrees.
                    if (beat) begin
                        beat_cnt <= sat_inc(beat_cnt);
                        if (beat_err) rd_err <= 1'b1;
                        if (m_axi_rlast) begin
                            m_axi_rready <= 1'b0;
                            last_served  <= owner;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign ch0_rd_grant  = grant0;
    assign ch1_rd_grant  = grant1;
    assign ch0_rd_data   = m_axi_rdata;
    assign ch1_rd_data   = m_axi_rdata;
    assign ch0_rd_valid  = beat & ~owner;
    assign ch1_rd_valid  = beat & owner;
    assign ch0_rd_done   = (state == DONE) & ~owner;
    assign ch1_rd_done   = (state == DONE) & owner;

    assign m_axi_arid    = AXI_ID;
    assign m_axi_arsize  = AXI_SIZE;
    assign m_axi_arburst = AXI_BURST;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus a randomized run, every cycle
// compared against a transaction-level model of the arbiter.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ch0_rd_req, ch1_rd_req;
    logic [29:0] ch0_rd_addr, ch1_rd_addr;
    logic [7:0]  ch0_rd_len, ch1_rd_len;
    logic        ch0_rd_grant, ch1_rd_grant;
    logic [63:0] ch0_rd_data, ch1_rd_data;
    logic        ch0_rd_valid, ch1_rd_valid;
    logic        ch0_rd_done, ch1_rd_done;
    logic [3:0]  m_axi_arid;
    logic [29:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid, m_axi_arready;
    logic [63:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;
    logic        rd_err;

    always #5 clk = ~clk;

    axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .ch0_rd_req(ch0_rd_req), .ch0_rd_addr(ch0_rd_addr), .ch0_rd_len(ch0_rd_len),
        .ch0_rd_grant(ch0_rd_grant), .ch0_rd_data(ch0_rd_data),
        .ch0_rd_valid(ch0_rd_valid), .ch0_rd_done(ch0_rd_done),
        .ch1_rd_req(ch1_rd_req), .ch1_rd_addr(ch1_rd_addr), .ch1_rd_len(ch1_rd_len),
        .ch1_rd_grant(ch1_rd_grant), .ch1_rd_data(ch1_rd_data),
        .ch1_rd_valid(ch1_rd_valid), .ch1_rd_done(ch1_rd_done),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
        .rd_err(rd_err)
    );

    // Transaction-level view of the arbiter: which phase of a burst is pending.
    typedef struct {
        bit          addr_wait;
        bit          data_wait;
        bit          closing;
        int          owner;
        int          last;
        logic [29:0] addr;
        int          len;
        bit          arvalid;
        bit          rready;
        bit          grant0;
        bit          grant1;
        bit          err;
        int          beats;
    } model_t;

    model_t cur, nxt;
    bit     model_ok = 1'b0;
    bit     ok_next;

    int n_vec = 0;
    int n_bad = 0;

    int v0, v1, d0, d1, g0, g1, av_cnt, rr_cnt;
    int gq[$];
    bit seen_g0, seen_g1;

    bit auto_slave, auto_req;
    int ar_pct, rv_pct, junk_pct, resp_pct, flip_pct;
    bit s_active;
    int s_len, s_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 60)
                $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit pct(input int p);
        return $urandom_range(0, 99) < p;
    endfunction

    task automatic compare_all();
        if (!model_ok) return;
        check("arvalid", m_axi_arvalid, cur.arvalid);
        check("araddr", m_axi_araddr, cur.addr);
        check("arlen", m_axi_arlen, cur.len);
        check("rready", m_axi_rready, cur.rready);
        check("grant0", ch0_rd_grant, cur.grant0);
        check("grant1", ch1_rd_grant, cur.grant1);
        check("done0", ch0_rd_done, cur.closing && cur.owner == 0);
        check("done1", ch1_rd_done, cur.closing && cur.owner == 1);
        check("valid0", ch0_rd_valid, cur.rready && m_axi_rvalid && cur.owner == 0);
        check("valid1", ch1_rd_valid, cur.rready && m_axi_rvalid && cur.owner == 1);
        check("rd_err", rd_err, cur.err);
        check("data0", ch0_rd_data, m_axi_rdata);
        check("data1", ch1_rd_data, m_axi_rdata);
        check("arid", m_axi_arid, 4'd0);
        check("arsize", m_axi_arsize, 3'b011);
        check("arburst", m_axi_arburst, 2'b01);
    endtask

    task automatic model_eval();
        bit bad;
        int w;
        ok_next = 1'b0;
        nxt = cur;
        if (!rst_n) begin
            nxt.addr_wait = 0; nxt.data_wait = 0; nxt.closing = 0;
            nxt.owner = 0; nxt.last = 1; nxt.addr = '0; nxt.len = 0;
            nxt.arvalid = 0; nxt.rready = 0; nxt.grant0 = 0; nxt.grant1 = 0;
            nxt.err = 0; nxt.beats = 0;
            ok_next = 1'b1;
        end else begin
            nxt.grant0 = 0;
            nxt.grant1 = 0;
            if (cur.closing) begin
                nxt.closing = 0;
            end else if (cur.addr_wait) begin
                if (m_axi_arready) begin
                    nxt.addr_wait = 0; nxt.arvalid = 0;
                    nxt.data_wait = 1; nxt.rready = 1; nxt.beats = 0;
                end
            end else if (cur.data_wait) begin
                if (m_axi_rvalid) begin
                    bad = (m_axi_rresp != 2'b00) ||
                          (m_axi_rlast && cur.beats != cur.len) ||
                          (!m_axi_rlast && cur.beats == cur.len);
                    if (bad) nxt.err = 1;
                    nxt.beats = (cur.beats >= 255) ? 255 : cur.beats + 1;
                    if (m_axi_rlast) begin
                        nxt.data_wait = 0; nxt.rready = 0;
                        nxt.closing = 1; nxt.last = cur.owner;
                    end
                end
            end else if (ch0_rd_req || ch1_rd_req) begin
                if (ch0_rd_req && ch1_rd_req) w = 1 - cur.last;
                else w = ch0_rd_req ? 0 : 1;
                nxt.owner = w;
                nxt.addr = (w == 1) ? ch1_rd_addr : ch0_rd_addr;
                nxt.len = (w == 1) ? int'(ch1_rd_len) : int'(ch0_rd_len);
                nxt.arvalid = 1; nxt.addr_wait = 1;
                nxt.grant0 = (w == 0); nxt.grant1 = (w == 1);
            end
        end
    endtask

    task automatic observe();
        if (ch0_rd_grant) begin gq.push_back(0); g0++; seen_g0 = 1; end
        if (ch1_rd_grant) begin gq.push_back(1); g1++; seen_g1 = 1; end
        v0 += int'(ch0_rd_valid);
        v1 += int'(ch1_rd_valid);
        d0 += int'(ch0_rd_done);
        d1 += int'(ch1_rd_done);
        av_cnt += int'(m_axi_arvalid);
        rr_cnt += int'(m_axi_rready);
    endtask

    task automatic slave_drive();
        m_axi_arready = pct(ar_pct);
        m_axi_rdata = {$urandom(), $urandom()};
        m_axi_rresp = pct(resp_pct) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (s_active) begin
            m_axi_rvalid = pct(rv_pct);
            m_axi_rlast = (s_cnt == s_len);
            if (pct(flip_pct)) m_axi_rlast = ~m_axi_rlast;
        end else begin
            m_axi_rvalid = pct(junk_pct);
            m_axi_rlast = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic slave_track();
        if (!rst_n) begin
            s_active = 0;
        end else begin
            if (m_axi_arvalid && m_axi_arready) begin
                s_active = 1; s_len = int'(m_axi_arlen); s_cnt = 0;
            end else if (s_active && m_axi_rvalid && m_axi_rready) begin
                if (m_axi_rlast) s_active = 0;
                else s_cnt++;
            end
        end
    endtask

    task automatic req_drive();
        if (ch0_rd_req && seen_g0) ch0_rd_req = 0;
        else if (!ch0_rd_req && pct(30)) begin
            ch0_rd_req = 1;
            ch0_rd_addr = 30'($urandom());
            ch0_rd_len = pct(3) ? 8'($urandom()) : 8'($urandom_range(0, 4));
        end
        if (ch1_rd_req && seen_g1) ch1_rd_req = 0;
        else if (!ch1_rd_req && pct(30)) begin
            ch1_rd_req = 1;
            ch1_rd_addr = 30'($urandom());
            ch1_rd_len = pct(3) ? 8'($urandom()) : 8'($urandom_range(0, 4));
        end
        seen_g0 = 0;
        seen_g1 = 0;
    endtask

    // One clock: drive, check away from the edge, advance the model with the edge.
    task automatic step();
        if (auto_slave) slave_drive();
        if (auto_req) req_drive();
        #1;
        compare_all();
        observe();
        model_eval();
        slave_track();
        @(posedge clk);
        cur = nxt;
        if (ok_next) model_ok = 1'b1;
        @(negedge clk);
    endtask

    task automatic clr();
        v0 = 0; v1 = 0; d0 = 0; d1 = 0; g0 = 0; g1 = 0; av_cnt = 0; rr_cnt = 0;
        gq.delete();
    endtask

    task automatic do_reset();
        rst_n = 0;
        ch0_rd_req = 0; ch1_rd_req = 0;
        ch0_rd_addr = '0; ch1_rd_addr = '0; ch0_rd_len = '0; ch1_rd_len = '0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0;
        m_axi_rresp = 2'b00; m_axi_rdata = '0;
        step();
        step();
        rst_n = 1;
        clr();
    endtask

    task automatic beat(input bit last);
        m_axi_rvalid = 1; m_axi_rlast = last;
        m_axi_rdata = {$urandom(), $urandom()};
        step();
        m_axi_rvalid = 0; m_axi_rlast = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        auto_slave = 0; auto_req = 0;
        seen_g0 = 0; seen_g1 = 0; s_active = 0; s_len = 0; s_cnt = 0;
        ar_pct = 100; rv_pct = 100; junk_pct = 0; resp_pct = 0; flip_pct = 0;
        do_reset();

        check("rst_arvalid", m_axi_arvalid, 0);
        check("rst_rready", m_axi_rready, 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_rd_err", rd_err, 0);

        // Single ch0 burst, four beats.
        ch0_rd_req = 1; ch0_rd_addr = 30'h100; ch0_rd_len = 8'd3; m_axi_arready = 1;
        step();
        check("t1_grant0", ch0_rd_grant, 1);
        check("t1_araddr", m_axi_araddr, 30'h100);
        check("t1_arlen", m_axi_arlen, 8'd3);
        ch0_rd_req = 0;
        step();
        beat(0); beat(0); beat(0); beat(1);
        step(); step();
        check("t1_valid_cnt", v0, 4);
        check("t1_valid1_cnt", v1, 0);
        check("t1_done_cnt", d0, 1);
        check("t1_grant_cnt", g0, 1);
        check("t1_err", rd_err, 0);

        // Both channels requesting continuously: grants alternate.
        do_reset();
        ch0_rd_req = 1; ch0_rd_addr = 30'h10; ch0_rd_len = 0;
        ch1_rd_req = 1; ch1_rd_addr = 30'h20; ch1_rd_len = 0;
        auto_slave = 1; ar_pct = 100; rv_pct = 100; junk_pct = 0; resp_pct = 0; flip_pct = 0;
        for (int i = 0; i < 80 && gq.size() < 4; i++) step();
        auto_slave = 0;
        if (gq.size() < 4) begin
            check("t2_grant_timeout", gq.size(), 4);
        end else begin
            check("t2_grant_a", gq[0], 0);
            check("t2_grant_b", gq[1], 1);
            check("t2_grant_c", gq[2], 0);
            check("t2_grant_d", gq[3], 1);
        end

        // arready held low for five cycles.
        do_reset();
        ch0_rd_req = 1; ch0_rd_addr = 30'h2AA; ch0_rd_len = 0; m_axi_arready = 0;
        step();
        ch0_rd_req = 0;
        clr();
        for (int i = 0; i < 5; i++) begin
            step();
            check("t3_araddr_hold", m_axi_araddr, 30'h2AA);
        end
        m_axi_arready = 1;
        step();
        m_axi_arready = 0;
        check("t3_arvalid_cycles", av_cnt, 6);
        check("t3_rready_early", rr_cnt, 0);
        beat(1);
        step();
        check("t3_done_cnt", d0, 1);

        // rvalid toggling 1,0,1,0 on a two-beat ch1 burst.
        do_reset();
        ch1_rd_req = 1; ch1_rd_addr = 30'h3000; ch1_rd_len = 8'd1; m_axi_arready = 1;
        step();
        ch1_rd_req = 0;
        step();
        clr();
        beat(0); step(); beat(1);
        check("t4_done_now", ch1_rd_done, 1);
        step();
        check("t4_valid_cnt", v1, 2);
        check("t4_done_cnt", d1, 1);
        check("t4_other_valid", v0, 0);

        // Early rlast raises the sticky error; the next burst still completes.
        do_reset();
        ch0_rd_req = 1; ch0_rd_addr = 30'h40; ch0_rd_len = 8'd3; m_axi_arready = 1;
        step();
        ch0_rd_req = 0;
        step();
        beat(0); beat(1);
        step();
        check("t5_err", rd_err, 1);
        check("t5_done_cnt", d0, 1);
        step();
        ch0_rd_req = 1; ch0_rd_addr = 30'h80; ch0_rd_len = 8'd0;
        step();
        ch0_rd_req = 0;
        step();
        beat(1);
        step(); step();
        check("t5_done_cnt2", d0, 2);
        check("t5_err_sticky", rd_err, 1);
        check("t5_valid_cnt", v0, 3);

        // Reset during the second beat aborts the burst.
        do_reset();
        ch0_rd_req = 1; ch0_rd_addr = 30'h500; ch0_rd_len = 8'd3; m_axi_arready = 1;
        step();
        ch0_rd_req = 0;
        step();
        beat(0);
        rst_n = 0;
        beat(0);
        rst_n = 1;
        check("t6_arvalid", m_axi_arvalid, 0);
        check("t6_rready", m_axi_rready, 0);
        check("t6_araddr", m_axi_araddr, 0);
        check("t6_arlen", m_axi_arlen, 0);
        check("t6_err", rd_err, 0);
        check("t6_done", ch0_rd_done, 0);
        v0 = 0;
        m_axi_rvalid = 1; m_axi_rlast = 1;
        step(); step();
        m_axi_rvalid = 0; m_axi_rlast = 0;
        check("t6_ignored_beats", v0, 0);
        ch1_rd_req = 1; ch1_rd_addr = 30'h600; ch1_rd_len = 8'd0;
        step();
        check("t6_grant1", ch1_rd_grant, 1);
        check("t6_araddr1", m_axi_araddr, 30'h600);
        ch1_rd_req = 0;
        step();
        beat(1);
        step();
        check("t6_done1", d1, 1);
        check("t6_no_done0", d0, 0);

        // Randomized traffic with stalls, error responses, bad rlast and occasional reset.
        do_reset();
        auto_slave = 1; auto_req = 1;
        ar_pct = 60; rv_pct = 70; junk_pct = 30; resp_pct = 3; flip_pct = 3;
        for (int i = 0; i < 4000; i++) begin
            rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
            step();
        end
        rst_n = 1;
        check("rand_bursts_seen", (g0 + g1) > 20, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 Parameter AXI_ID, default 4'd0, meaning constant value driven on m_axi_arid.
REQ-002 Parameter AXI_SIZE, default 3'b011, meaning constant arsize (8-byte beats).
REQ-003 Parameter AXI_BURST, default 2'b01, meaning constant arburst (INCR).
REQ-004 Port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1, meaning reset; synchronous and active-low.
REQ-006 Ports chN_rd_req (N=0,1), input, 1, meaning requester N wants a burst; level, held until grant.
REQ-007 Ports chN_rd_addr, input, 30, meaning burst start address of requester N.
REQ-008 Ports chN_rd_len, input, 8, meaning AXI len (beats-1) of requester N.
REQ-009 Ports chN_rd_grant, output, 1, meaning one-cycle pulse when requester N's request is latched.
REQ-010 Ports chN_rd_data, output, 64, meaning read beat data (both copies = m_axi_rdata).
REQ-011 Ports chN_rd_valid, output, 1, meaning beat for requester N accepted this cycle.
REQ-012 Ports chN_rd_done, output, 1, meaning one-cycle pulse after requester N's last beat.
REQ-013 Port m_axi_arid/araddr/arlen/arsize/arburst, output, 4/30/8/3/2, meaning AXI read address.
REQ-014 Port m_axi_arvalid, output, 1; m_axi_arready, input, 1.
REQ-015 Ports m_axi_rdata (input 64), m_axi_rresp (input 2), m_axi_rlast (input 1), m_axi_rvalid (input 1), m_axi_rready (output 1).
REQ-016 Port rd_err, output, 1, meaning sticky error flag.

Function
REQ-017 FSM states: IDLE, AR, R, DONE; state register updates every clk.
REQ-018 IDLE: if any chN_rd_req, select a winner, latch its addr/len into m_axi_araddr/m_axi_arlen, pulse its chN_rd_grant, set m_axi_arvalid=1, go AR next cycle; otherwise stay.
REQ-019 Arbitration round-robin: both requesting -> grant the channel not served last; single requester wins immediately; pointer after reset favours ch0.
REQ-020 Last-served pointer updates only on entry to DONE.
REQ-021 AR: m_axi_arvalid and address/len held stable until arvalid&arready; on that cycle arvalid deasserts (registered), beat counter clears, go R.
REQ-022 R: m_axi_rready=1 registered from R entry; rready=0 in all other states.
REQ-023 Each rvalid&rready beat: owner's chN_rd_valid=1 same cycle (combinational), counter increments, saturating at 255.
REQ-024 Beat with rlast=1 -> go DONE; m_axi_rready deasserts the following cycle.
REQ-025 DONE: lasts exactly one cycle; owner's chN_rd_done=1 for that cycle; go IDLE.
REQ-026 Minimum gap: new request accepted no earlier than IDLE cycle after DONE.
REQ-027 rd_err sets when a beat has rresp!=2'b00, when rlast arrives with count!=arlen, or when count reaches arlen without rlast; clears only on reset.
REQ-028 On count/rlast mismatch the FSM still follows rlast; no beat is dropped.
REQ-029 Request deasserted after grant has no effect on the in-flight burst.
REQ-030 arid=AXI_ID, arsize=AXI_SIZE, arburst=AXI_BURST always.
REQ-031 chN_rd_valid for the non-owner is always 0.

Reset
REQ-032 rst_n=0 sampled at clk: state=IDLE, arvalid=0, rready=0, araddr=0, arlen=0, grants/valids/dones=0, rd_err=0, counter=0, pointer favours ch0.
REQ-033 Reset mid-burst aborts immediately; no done pulse; further AXI beats ignored until a new grant.

Verification
REQ-034 ch0 req addr=0x100 len=3, arready immediate, 4 beats with rlast on 4th -> ch0_rd_grant 1 cycle, araddr=0x100 arlen=3, four ch0_rd_valid, ch0_rd_done 1 cycle, rd_err=0.
REQ-035 ch0 and ch1 requesting continuously, len=0 -> grants alternate ch0,ch1,ch0,ch1.
REQ-036 arready held low 5 cycles -> arvalid/araddr stable for 6 cycles, no rready before handshake.
REQ-037 rvalid toggling 1,0,1,0 for len=1 -> exactly 2 valid beats, done after 2nd beat.
REQ-038 len=3 with rlast on beat 2 -> rd_err=1, done issued, FSM back to IDLE; next burst completes normally with rd_err still 1.
REQ-039 rst_n low during R beat 2 -> all outputs to reset values next cycle; following ch1 request granted normally.
